// File: rtl/rca_pkg.sv
// Shared definitions for the multi-precision RCA sequencer.
package rca_pkg;

    // Width of the external ripple-carry adder this controller drives.
    localparam int RCA_W = 16;

    // Sequencer states: wait for operands, walk the words, hold the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/RCA_16bit.sv
// Plain 16-bit ripple-carry adder that sits beside the sequencer.
module RCA_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    // Full 17-bit addition; the top bit is the carry out of the word.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    end

endmodule

// File: rtl/rca_word_sel.sv
// Picks word idx out of the latched A and B operands for the shared adder.
module rca_word_sel #(
    parameter int W      = 16,
    parameter int NWORDS = 4,
    parameter int IW     = 2
) (
    input  logic [W*NWORDS-1:0] a_i,
    input  logic [W*NWORDS-1:0] b_i,
    input  logic [IW-1:0]       idx_i,
    output logic [W-1:0]        a_o,
    output logic [W-1:0]        b_o
);

    // Explicit compare-per-word mux so an unused index just yields zero.
    always_comb begin
        a_o = '0;
        b_o = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx_i == IW'(i)) begin
                a_o = a_i[i*W +: W];
                b_o = b_i[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/rca_mp_sequencer.sv
// Multi-precision add controller: steps one shared W-bit adder over NWORDS
// operand words LSW first, carrying between words in a register.
module rca_mp_sequencer
    import rca_pkg::*;
#(
    parameter int W      = RCA_W,
    parameter int NWORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W*NWORDS-1:0] a,
    input  logic [W*NWORDS-1:0] b,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W*NWORDS-1:0] sum,
    output logic                cout,
    output logic                busy,
    output logic [W-1:0]        add_a,
    output logic [W-1:0]        add_b,
    output logic                add_cin,
    input  logic [W-1:0]        add_sum,
    input  logic                add_cout
);

    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [W*NWORDS-1:0] a_q, a_d;
    logic [W*NWORDS-1:0] b_q, b_d;
    logic [W*NWORDS-1:0] sum_q, sum_d;
    logic                cout_q, cout_d;
    logic [W-1:0]        selA, selB;
    logic                running;

    rca_word_sel #(
        .W      (W),
        .NWORDS (NWORDS),
        .IW     (IW)
    ) u_word_sel (
        .a_i   (a_q),
        .b_i   (b_q),
        .idx_i (idx_q),
        .a_o   (selA),
        .b_o   (selB)
    );

    // Next-state, word stepping and handshake outputs; adder ports stay quiet outside RUN.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        running   = 1'b0;
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                running = 1'b1;
                for (int i = 0; i < NWORDS; i++) begin
                    if (idx_q == IW'(i)) begin
                        sum_d[i*W +: W] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        add_a   = running ? selA : '0;
        add_b   = running ? selB : '0;
        add_cin = running ? carry_q : 1'b0;
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_rca_mp_sequencer.sv
// Bench for rca_mp_sequencer wired to RCA_16bit, with a scoreboard of expected sums.
module tb_rca_mp_sequencer;

    localparam int W      = 16;
    localparam int NWORDS = 4;
    localparam int OW     = W * NWORDS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          cin = 1'b0;
    logic [OW-1:0] a = '0;
    logic [OW-1:0] b = '0;
    logic          in_ready, out_valid, cout, busy;
    logic [OW-1:0] sum;
    logic [W-1:0]  add_a, add_b, add_sum;
    logic          add_cin, add_cout;

    rca_mp_sequencer #(.W(W), .NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    RCA_16bit u_rca (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] sum;
        logic          cout;
    } result_t;

    typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;

    result_t       expQ[$];
    int            testsRun = 0;
    int            testsFailed = 0;
    int            edgeCount = 0;
    int            acceptEdge = 0;
    int            prevAcceptEdge = -1;
    bit            latencyPending = 1'b0;
    bit            b2bMode = 1'b0;
    mstate_t       mState = M_IDLE;
    int            mK = 0;
    logic          mCarry = 1'b0;
    logic [OW-1:0] mA = '0;
    logic [OW-1:0] mB = '0;
    logic [OW:0]   fullSum;
    logic [W:0]    wordSum;

    task automatic checkOutput(input string tag, input logic [OW-1:0] observed, input logic [OW-1:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Count rising edges so latency and spacing can be measured in cycles.
    always @(posedge clk) edgeCount++;

    // Cycle model: check outputs against the expected state, then predict the coming edge.
    always @(negedge clk) begin
        if (edgeCount > 0) begin
            checkOutput("in_ready", OW'(in_ready), OW'(mState == M_IDLE && !rst));
            checkOutput("out_valid", OW'(out_valid), OW'(mState == M_DONE));
            checkOutput("busy", OW'(busy), OW'(mState != M_IDLE));
            if (mState == M_RUN) begin
                checkOutput("add_a", OW'(add_a), OW'(mA[mK*W +: W]));
                checkOutput("add_b", OW'(add_b), OW'(mB[mK*W +: W]));
                checkOutput("add_cin", OW'(add_cin), OW'(mCarry));
            end else begin
                checkOutput("add_quiet", {add_a, add_b, 31'b0, add_cin}, '0);
            end
            if (mState == M_DONE) begin
                if (latencyPending) begin
                    checkOutput("latency", OW'(edgeCount - acceptEdge), OW'(NWORDS));
                    latencyPending = 1'b0;
                end
                if (expQ.size() == 0) begin
                    checkOutput("sb_underflow", OW'(1), OW'(0));
                end else begin
                    checkOutput("sum", sum, expQ[0].sum);
                    checkOutput("cout", OW'(cout), OW'(expQ[0].cout));
                end
            end
            if (rst) begin
                mState = M_IDLE;
                expQ.delete();
                latencyPending = 1'b0;
            end else begin
                case (mState)
                    M_IDLE: begin
                        if (in_valid) begin
                            fullSum = {1'b0, a} + {1'b0, b} + {{OW{1'b0}}, cin};
                            expQ.push_back('{sum: fullSum[OW-1:0], cout: fullSum[OW]});
                            mA = a;
                            mB = b;
                            mCarry = cin;
                            mK = 0;
                            acceptEdge = edgeCount + 1;
                            latencyPending = 1'b1;
                            if (b2bMode && prevAcceptEdge >= 0) begin
                                checkOutput("interval", OW'(acceptEdge - prevAcceptEdge), OW'(NWORDS + 2));
                            end
                            prevAcceptEdge = b2bMode ? acceptEdge : -1;
                            mState = M_RUN;
                        end
                    end
                    M_RUN: begin
                        wordSum = {1'b0, mA[mK*W +: W]} + {1'b0, mB[mK*W +: W]} + {{W{1'b0}}, mCarry};
                        mCarry = wordSum[W];
                        if (mK == NWORDS - 1) begin
                            mState = M_DONE;
                        end else begin
                            mK++;
                        end
                    end
                    M_DONE: begin
                        if (out_ready) begin
                            void'(expQ.pop_front());
                            mState = M_IDLE;
                        end
                    end
                    default: mState = M_IDLE;
                endcase
            end
        end
    end

    // Offer one operand set and hold in_valid until the sequencer takes it.
    task automatic applyStimulus(input logic [OW-1:0] aIn, input logic [OW-1:0] bIn, input logic cinIn);
        bit taken;
        taken = 1'b0;
        a = aIn;
        b = bIn;
        cin = cinIn;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) checkOutput("accept_timeout", OW'(0), OW'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Consume one result, bounded so a stuck sequencer still reaches the summary.
    task automatic waitResult();
        bit seen;
        seen = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("result_timeout", OW'(0), OW'(1));
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // Directed cases, then a back-to-back random stream.
    initial begin
        bit seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_sum", sum, '0);
        checkOutput("reset_cout", OW'(cout), OW'(0));
        checkOutput("reset_in_ready", OW'(in_ready), OW'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        waitResult();
        @(negedge clk);
        checkOutput("t1_sum", sum, 64'h0000_0000_0001_0000);
        checkOutput("t1_cout", OW'(cout), OW'(0));

        @(posedge clk);
        #1;
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        waitResult();
        @(negedge clk);
        checkOutput("t2_sum", sum, 64'h0);
        checkOutput("t2_cout", OW'(cout), OW'(1));

        @(posedge clk);
        #1;
        applyStimulus(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("t3_done_timeout", OW'(0), OW'(1));
        @(posedge clk);
        #1;
        a = 64'hDEAD_BEEF_0000_0001;
        b = 64'h1111_2222_3333_4444;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("t3_hold_valid", OW'(out_valid), OW'(1));
        checkOutput("t3_hold_sum", sum, 64'h1111_1111_1111_1100);
        checkOutput("t3_hold_cout", OW'(cout), OW'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        waitResult();

        applyStimulus(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("t4_out_valid", OW'(out_valid), OW'(0));
        checkOutput("t4_sum", sum, '0);
        checkOutput("t4_cout", OW'(cout), OW'(0));
        checkOutput("t4_busy", OW'(busy), OW'(0));
        @(posedge clk);
        #1;
        applyStimulus(64'd5, 64'd7, 1'b0);
        waitResult();
        @(negedge clk);
        checkOutput("t4_sum_after", sum, 64'd12);

        @(posedge clk);
        #1;
        b2bMode = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6 * 8; i++) begin
            a = {$urandom, $urandom};
            b = (i % 7 == 3) ? ~a : {$urandom, $urandom};
            cin = $urandom_range(0, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("t5_drain_timeout", OW'(0), OW'(1));
        @(posedge clk);
        #1;
        b2bMode = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("sb_drain", OW'(expQ.size()), OW'(0));
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Hard stop in case the stimulus itself wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
